gain_shift_ctrl: RTL and testbench
==================================

// Module: gain_shift_ctrl
// PURPOSE
//  Automatic gain controller for the 48-bit->16-bit shift-and-truncate stage of the DDC.
//  - Measures peak |sample| over fixed windows of valid samples.
//  - Computes the left shift that fits the peak into the 16-bit output, with headroom.
//  - Drives scaled_coeff with fast attack / slow decay; also offers a manual override.
//  - Sits beside the shift stage and sees the same 48-bit stream as that stage.
// PARAMETERS
//  DW         48  input sample width (signed, two's complement)
//  CW         16  scaled_coeff width
//  WIN_LOG2   10  window length = 2**WIN_LOG2 valid samples
//  MARGIN     1   headroom bits kept below full scale
//  HOLD       4   consecutive "can grow" windows before shift increments by 1
//  MAX_SHIFT  32  upper clamp for scaled_coeff
//  INIT_SHIFT 0   scaled_coeff value after reset
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous active-high reset
//  enable        in   1   1 = run windows; 0 = clear window state, hold scaled_coeff
//  manual_mode   in   1   1 = scaled_coeff follows manual_shift
//  manual_shift  in   6   manual shift value, clamped to MAX_SHIFT
//  sample_in     in   DW  monitored sample
//  sample_valid  in   1   sample_in qualifier
//  scaled_coeff  out  CW  shift amount to the shift stage (reset INIT_SHIFT)
//  coeff_update  out  1   1-cycle pulse on any change of scaled_coeff (reset 0)
//  clip_flag     out  1   1-cycle pulse: last window peak would wrap at current shift (reset 0)
//  win_peak      out  DW  peak |sample| of the last completed window (reset 0)
// BEHAVIOUR
//  - Abs value: |x|; -2**(DW-1) saturates to 2**(DW-1)-1.
//  - Peak register: max of abs over valid samples. A window closes on the 2**WIN_LOG2-th valid sample.
//  - At close: peak is copied to win_peak. The peak register restarts with that closing sample's
//    successor, so no sample is lost. Samples arriving during COMPUTE/DECIDE count toward the new window.
//  - FSM states: IDLE -> (window close) COMPUTE -> DECIDE -> IDLE. Each state lasts 1 cycle.
//    A window close can never occur while the FSM is busy (WIN_LOG2 >= 2 is required).
//  - COMPUTE: lz = leading zeros of win_peak (lz = DW when peak = 0).
//    tgt = clamp(lz - 1 - MARGIN, 0, MAX_SHIFT).
//  - DECIDE, with cur = scaled_coeff:
//    - tgt < cur: scaled_coeff <= tgt, hold_cnt <= 0 (attack).
//    - tgt > cur: hold_cnt++. When hold_cnt reaches HOLD: scaled_coeff <= cur + 1, hold_cnt <= 0.
//    - tgt == cur: hold_cnt <= 0.
//    - clip_flag pulses in DECIDE when (lz - 1) < cur, i.e. the shift stage wrapped during the window.
//  - Latency: scaled_coeff and coeff_update register 3 clk after the cycle of the closing valid sample.
//  - Manual mode:
//    - scaled_coeff <= min(manual_shift, MAX_SHIFT) on the next clk, with coeff_update if changed.
//    - Windows keep running (win_peak and clip_flag stay live); DECIDE does not write scaled_coeff.
//    - hold_cnt is held at 0.
//    - Leaving manual mode resumes auto control from the current value.
//  - enable = 0: sample counter, peak, hold_cnt and FSM clear to 0/IDLE within 1 clk.
//    scaled_coeff and win_peak hold. An in-flight COMPUTE/DECIDE is abandoned.
//  - Simultaneous manual_mode rise and DECIDE: manual value wins.
//  - rst mid-operation: every register returns immediately to its reset value.
// STRUCTURE
//  - gain_ctrl_pkg: DW/CW widths, MAX_SHIFT, FSM state encoding (IDLE/COMPUTE/DECIDE),
//    and the abs-saturate function.
//  - One sub-module, lzc48: combinational leading-zero counter, DW in -> 6-bit count out.
// TESTING
//  1. rst then constant sample 0x0000_0000_1000 (peak 2**12, lz=35), MARGIN=1:
//     tgt=33 clamps to 32; scaled_coeff reaches 32 only after 32*HOLD=128 windows, +1 per 4 windows.
//  2. At shift 32, one sample 0x0100_0000_0000 (lz=7): scaled_coeff -> 5 three clk after window close;
//     clip_flag and coeff_update pulse once.
//  3. Sample -2**47 in a window at shift 0: win_peak = 0x7FFF_FFFF_FFFF, tgt=0, no change, no clip.
//  4. manual_mode=1, manual_shift=40: scaled_coeff=32 next clk with coeff_update.
//     A loud window does not change it; clip_flag still pulses.
//  5. Drop enable mid-window after 500 samples, re-raise: next window closes after a full 1024 samples.
//     sample_valid gaps do not change the count.
//  6. Assert rst during DECIDE: scaled_coeff=INIT_SHIFT, no coeff_update, win_peak=0.

Source files
------------

// File: rtl/gain_ctrl_pkg.sv
// Shared widths, FSM encoding and the saturating absolute value used by the
// automatic gain controller of the DDC shift-and-truncate stage.
package gain_ctrl_pkg;

    localparam int DW        = 48;
    localparam int CW        = 16;
    localparam int LZW       = 6;
    localparam int MAX_SHIFT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DECIDE  = 2'd2
    } state_t;

    // The most negative input has no positive twin, so it saturates to full scale.
    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
        if (!x[DW-1]) begin
            return x;
        end
        if (x == {1'b1, {(DW-1){1'b0}}}) begin
            return {1'b0, {(DW-1){1'b1}}};
        end
        return -x;
    endfunction

endpackage

// File: rtl/lzc48.sv
// Combinational leading-zero counter; an all-zero input reports DW.
module lzc48
    import gain_ctrl_pkg::*;
(
    input  logic [DW-1:0]  value,
    output logic [LZW-1:0] count
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        count = LZW'(DW);
        for (int i = 0; i < DW; i++) begin
            if (value[i]) begin
                count = LZW'(DW - 1 - i);
            end
        end
    end

endmodule

// File: rtl/gain_shift_ctrl.sv
// Windowed peak detector driving the shift amount of the 48->16 bit truncation
// stage: fast attack, slow held decay, plus a manual override.
module gain_shift_ctrl
    import gain_ctrl_pkg::*;
#(
    parameter int WIN_LOG2   = 10,
    parameter int MARGIN     = 1,
    parameter int HOLD       = 4,
    parameter int INIT_SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          manual_mode,
    input  logic [5:0]    manual_shift,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic [CW-1:0] scaled_coeff,
    output logic          coeff_update,
    output logic          clip_flag,
    output logic [DW-1:0] win_peak
);

    localparam int HW = $clog2(HOLD + 1);

    state_t              state_q;
    state_t              state_d;
    logic [WIN_LOG2-1:0] sample_cnt;
    logic [DW-1:0]       peak;
    logic [DW-1:0]       sample_abs;
    logic [DW-1:0]       peak_next;
    logic [LZW-1:0]      peak_lz;
    logic [LZW-1:0]      lz_q;
    logic [LZW-1:0]      tgt_q;
    logic [HW-1:0]       hold_cnt;
    logic [CW-1:0]       manual_coeff;
    logic                win_close;

    // Largest shift that still leaves MARGIN headroom bits plus the sign bit.
    function automatic logic [LZW-1:0] target_shift(input logic [LZW-1:0] lz);
        int t;
        t = int'(lz) - 1 - MARGIN;
        if (t < 0) begin
            t = 0;
        end
        if (t > MAX_SHIFT) begin
            t = MAX_SHIFT;
        end
        return LZW'(t);
    endfunction

    assign sample_abs   = abs_sat(sample_in);
    assign peak_next    = (sample_abs > peak) ? sample_abs : peak;
    assign win_close    = enable && sample_valid && (sample_cnt == '1);
    assign manual_coeff = (manual_shift > LZW'(MAX_SHIFT)) ? CW'(MAX_SHIFT) : CW'(manual_shift);

    lzc48 u_lzc (
        .value (win_peak),
        .count (peak_lz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_close) state_d = COMPUTE;
            COMPUTE: state_d = DECIDE;
            DECIDE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

    // Manual mode is evaluated last so it overrides a DECIDE in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt   <= '0;
            peak         <= '0;
            win_peak     <= '0;
            lz_q         <= '0;
            tgt_q        <= '0;
            hold_cnt     <= '0;
            scaled_coeff <= CW'(INIT_SHIFT);
            coeff_update <= 1'b0;
            clip_flag    <= 1'b0;
        end else begin
            coeff_update <= 1'b0;
            clip_flag    <= 1'b0;
            if (!enable) begin
                sample_cnt <= '0;
                peak       <= '0;
                hold_cnt   <= '0;
            end else begin
                if (sample_valid) begin
                    sample_cnt <= sample_cnt + WIN_LOG2'(1);
                    if (win_close) begin
                        win_peak <= peak_next;
                        peak     <= '0;
                    end else begin
                        peak <= peak_next;
                    end
                end
                if (state_q == COMPUTE) begin
                    lz_q  <= peak_lz;
                    tgt_q <= target_shift(peak_lz);
                end
                if (state_q == DECIDE) begin
                    clip_flag <= (int'(lz_q) - 1) < int'(scaled_coeff);
                    if (!manual_mode) begin
                        if (CW'(tgt_q) < scaled_coeff) begin
                            scaled_coeff <= CW'(tgt_q);
                            hold_cnt     <= '0;
                            coeff_update <= 1'b1;
                        end else if (CW'(tgt_q) > scaled_coeff) begin
                            if (hold_cnt == HW'(HOLD - 1)) begin
                                scaled_coeff <= scaled_coeff + CW'(1);
                                hold_cnt     <= '0;
                                coeff_update <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                        end else begin
                            hold_cnt <= '0;
                        end
                    end
                end
                if (manual_mode) begin
                    scaled_coeff <= manual_coeff;
                    coeff_update <= (manual_coeff != scaled_coeff);
                    hold_cnt     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gain_shift_ctrl.sv
// Bench for gain_shift_ctrl: directed scenarios and random traffic compared every
// cycle against a window-level behavioural model, with literal spot checks.
module tb_gain_shift_ctrl;

    localparam int WIN_LOG2 = 4;
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int MARGIN   = 1;
    localparam int HOLD     = 4;
    localparam int INIT     = 0;
    localparam longint MAXA = (longint'(1) <<< 47) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        manual_mode = 1'b0;
    logic [5:0]  manual_shift = '0;
    logic [47:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] scaled_coeff;
    logic        coeff_update;
    logic        clip_flag;
    logic [47:0] win_peak;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int clip_cnt = 0;

    longint m_peak = 0, m_win = 0;
    int     m_cnt = 0, m_coeff = INIT, m_hold = 0, m_lz = 0, m_cyc = 0, m_due = 0;
    bit     m_pend = 0, m_upd = 0, m_clip = 0;

    gain_shift_ctrl #(
        .WIN_LOG2   (WIN_LOG2),
        .MARGIN     (MARGIN),
        .HOLD       (HOLD),
        .INIT_SHIFT (INIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .manual_mode  (manual_mode),
        .manual_shift (manual_shift),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .scaled_coeff (scaled_coeff),
        .coeff_update (coeff_update),
        .clip_flag    (clip_flag),
        .win_peak     (win_peak)
    );

    always #5 clk = ~clk;

    function automatic longint absModel(input logic [47:0] s);
        longint v;
        v = longint'($signed(s));
        if (v < 0) v = -v;
        if (v > MAXA) v = MAXA;
        return v;
    endfunction

    function automatic int lzModel(input longint v);
        for (int i = 47; i >= 0; i--) begin
            if (v[i]) return 47 - i;
        end
        return 48;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic man, input logic [5:0] ms,
                                 input logic [47:0] s, input logic v);
        @(negedge clk);
        enable       = en;
        manual_mode  = man;
        manual_shift = ms;
        sample_in    = s;
        sample_valid = v;
    endtask

    task automatic feedWindow(input logic [47:0] s, input logic man, input logic [5:0] ms);
        repeat (WIN) applyStimulus(1'b1, man, ms, s, 1'b1);
    endtask

    task automatic idle(input int n, input logic man, input logic [5:0] ms);
        repeat (n) applyStimulus(1'b1, man, ms, 48'h0, 1'b0);
    endtask

    // Window-level model: a close schedules its decision two edges later; manual wins last.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_coeff = INIT; m_upd = 0; m_clip = 0; m_win = 0; m_cnt = 0;
            m_peak = 0; m_hold = 0; m_pend = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            m_upd = 0;
            m_clip = 0;
            if (!enable) begin
                m_cnt = 0; m_peak = 0; m_hold = 0; m_pend = 0;
            end else begin
                if (m_pend && m_cyc == m_due) begin
                    int tgt;
                    m_pend = 0;
                    tgt = m_lz - 1 - MARGIN;
                    if (tgt < 0) tgt = 0;
                    if (tgt > 32) tgt = 32;
                    m_clip = (m_lz - 1) < m_coeff;
                    if (!manual_mode) begin
                        if (tgt < m_coeff) begin
                            m_coeff = tgt; m_upd = 1; m_hold = 0;
                        end else if (tgt > m_coeff) begin
                            m_hold++;
                            if (m_hold == HOLD) begin
                                m_coeff++; m_upd = 1; m_hold = 0;
                            end
                        end else begin
                            m_hold = 0;
                        end
                    end
                end
                if (sample_valid) begin
                    longint a;
                    a = absModel(sample_in);
                    if (a > m_peak) m_peak = a;
                    m_cnt++;
                    if (m_cnt == WIN) begin
                        m_win = m_peak; m_lz = lzModel(m_peak);
                        m_pend = 1; m_due = m_cyc + 2;
                        m_cnt = 0; m_peak = 0;
                    end
                end
                if (manual_mode) begin
                    int nv;
                    nv = (int'(manual_shift) > 32) ? 32 : int'(manual_shift);
                    if (nv != m_coeff) m_upd = 1;
                    m_coeff = nv;
                    m_hold = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("scaled_coeff", 64'(scaled_coeff), 64'(m_coeff));
            checkOutput("coeff_update", 64'(coeff_update), 64'(m_upd));
            checkOutput("clip_flag", 64'(clip_flag), 64'(m_clip));
            checkOutput("win_peak", 64'(win_peak), 64'(m_win));
            upd_cnt  += int'(coeff_update);
            clip_cnt += int'(clip_flag);
        end
    end

    initial begin
        logic [63:0]        w;
        logic signed [47:0] rs;
        logic               man;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("reset_coeff", 64'(scaled_coeff), 64'(INIT));
        checkOutput("reset_update", 64'(coeff_update), 64'd0);
        checkOutput("reset_clip", 64'(clip_flag), 64'd0);
        checkOutput("reset_win_peak", 64'(win_peak), 64'd0);

        $display("[TB] slow decay toward shift 32");
        upd_cnt = 0; clip_cnt = 0;
        repeat (132) feedWindow(48'h0000_0000_1000, 1'b0, 6'd0);
        idle(4, 1'b0, 6'd0); #1;
        checkOutput("ramp_coeff", 64'(scaled_coeff), 64'd32);
        checkOutput("ramp_updates", 64'(upd_cnt), 64'd32);
        checkOutput("ramp_clips", 64'(clip_cnt), 64'd0);

        $display("[TB] attack on a single loud sample");
        upd_cnt = 0; clip_cnt = 0;
        applyStimulus(1'b1, 1'b0, 6'd0, 48'h0100_0000_0000, 1'b1);
        repeat (WIN - 1) applyStimulus(1'b1, 1'b0, 6'd0, 48'h0, 1'b1);
        idle(4, 1'b0, 6'd0); #1;
        checkOutput("attack_coeff", 64'(scaled_coeff), 64'd5);
        checkOutput("attack_updates", 64'(upd_cnt), 64'd1);
        checkOutput("attack_clips", 64'(clip_cnt), 64'd1);

        $display("[TB] most negative sample at shift 0");
        feedWindow(48'h8000_0000_0000, 1'b0, 6'd0);
        idle(4, 1'b0, 6'd0); #1;
        upd_cnt = 0; clip_cnt = 0;
        feedWindow(48'h8000_0000_0000, 1'b0, 6'd0);
        idle(4, 1'b0, 6'd0); #1;
        checkOutput("neg_win_peak", 64'(win_peak), 64'h7FFF_FFFF_FFFF);
        checkOutput("neg_coeff", 64'(scaled_coeff), 64'd0);
        checkOutput("neg_updates", 64'(upd_cnt), 64'd0);
        checkOutput("neg_clips", 64'(clip_cnt), 64'd0);

        $display("[TB] manual override");
        upd_cnt = 0; clip_cnt = 0;
        applyStimulus(1'b1, 1'b1, 6'd40, 48'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 6'd40, 48'h0, 1'b0); #1;
        checkOutput("manual_coeff", 64'(scaled_coeff), 64'd32);
        checkOutput("manual_updates", 64'(upd_cnt), 64'd1);
        feedWindow(48'h8000_0000_0000, 1'b1, 6'd40);
        idle(4, 1'b1, 6'd40); #1;
        checkOutput("manual_hold_coeff", 64'(scaled_coeff), 64'd32);
        checkOutput("manual_hold_updates", 64'(upd_cnt), 64'd1);
        checkOutput("manual_clips", 64'(clip_cnt), 64'd1);
        feedWindow(48'h8000_0000_0000, 1'b0, 6'd0);
        idle(4, 1'b0, 6'd0); #1;
        checkOutput("resume_coeff", 64'(scaled_coeff), 64'd0);

        $display("[TB] enable drop mid-window");
        repeat (WIN / 2) applyStimulus(1'b1, 1'b0, 6'd0, 48'h0000_1234_0000, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 6'd0, 48'h0, 1'b0);
        for (int i = 0; i < WIN - 1; i++) begin
            applyStimulus(1'b1, 1'b0, 6'd0, 48'h55, 1'b1);
            applyStimulus(1'b1, 1'b0, 6'd0, 48'h0, 1'b0);
        end
        idle(4, 1'b0, 6'd0); #1;
        checkOutput("short_window_peak", 64'(win_peak), 64'h7FFF_FFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 6'd0, 48'h55, 1'b1);
        idle(4, 1'b0, 6'd0); #1;
        checkOutput("full_window_peak", 64'(win_peak), 64'h55);

        $display("[TB] random traffic");
        man = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            w  = {$urandom, $urandom};
            rs = w[47:0];
            rs = rs >>> $urandom_range(0, 47);
            if ($urandom_range(0, 99) == 0) man = ~man;
            applyStimulus(($urandom_range(0, 99) != 0), man, 6'($urandom_range(0, 63)),
                          rs, ($urandom_range(0, 9) < 7));
        end

        $display("[TB] reset during DECIDE");
        applyStimulus(1'b1, 1'b1, 6'd20, 48'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 48'h0, 1'b0);
        feedWindow(48'h0000_0000_1000, 1'b0, 6'd0);
        applyStimulus(1'b1, 1'b0, 6'd0, 48'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_coeff", 64'(scaled_coeff), 64'(INIT));
        checkOutput("rst_update", 64'(coeff_update), 64'd0);
        checkOutput("rst_win_peak", 64'(win_peak), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        upd_cnt = 0;
        idle(4, 1'b0, 6'd0); #1;
        checkOutput("post_rst_coeff", 64'(scaled_coeff), 64'(INIT));
        checkOutput("post_rst_updates", 64'(upd_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
